// File: rtl/pipe_alu_pkg.sv
// Shared definitions for the pipelined ALU / register-file datapath.
// Holds the opcode encodings and the record carried through the EX and WB stages.
// The record fields use fixed maximum widths so that one package type serves every
// parameterisation. Instances keep DW <= 64, RW <= 8 and AW <= 32, and only the low bits are used.
package pipe_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_RSH = 3'b100;
  localparam logic [2:0] OP_LSH = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int unsigned DW_MAX = 64;
  localparam int unsigned RW_MAX = 8;
  localparam int unsigned AW_MAX = 32;

  typedef struct packed {
    logic              v;
    logic [RW_MAX-1:0] rd;
    logic              rf_we;
    logic              mem_we;
    logic [AW_MAX-1:0] addr;
    logic [DW_MAX-1:0] data;
    logic              div0;
  } stage_t;

endpackage

// File: rtl/pipelined_alu_rf_if.sv
// Instruction / result bus between the sequencer (master) and the datapath core (slave).
interface pipelined_alu_rf_if #(
  parameter int unsigned DW     = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned MDEPTH = 256
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned AW = $clog2(MDEPTH);

  logic          in_valid;
  logic [RW-1:0] rs1;
  logic [RW-1:0] rs2;
  logic [RW-1:0] rd;
  logic [2:0]    func;
  logic          rf_we;
  logic          mem_we;
  logic [AW-1:0] addr;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;
  logic          err_div0;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport master (
    output in_valid, rs1, rs2, rd, func, rf_we, mem_we, addr, mem_raddr,
    input  res_valid, res_data, res_rd, err_div0, mem_rdata
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, rf_we, mem_we, addr, mem_raddr,
    output res_valid, res_data, res_rd, err_div0, mem_rdata
  );
endinterface

// File: rtl/pipe_alu_exec.sv
// Combinational ALU shared by the EX stage and the operand forward path.
// Optional multiplier: define PIPE_ALU_MUL_EN; otherwise opcode 011 yields 0.
module pipe_alu_exec
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [2:0]    func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          div0
);
  localparam int unsigned SW = (DW > 1) ? $clog2(DW) : 1;

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  // Decode the opcode into a single result; divide by zero saturates to all-ones.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    unique case (func)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_DIV: begin
        if (b == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = a / b;
        end
      end
      OP_MUL: begin
`ifdef PIPE_ALU_MUL_EN
        result = a * b;
`else
        result = '0;
`endif
      end
      OP_RSH: result = a >> shamt;
      OP_LSH: result = a << shamt;
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_alu_rf.sv
// Four-stage datapath core: operand read with bypass, execute, RF writeback, memory store.
// Forwarding from the ID and EX stages removes every RAW stall.
// PIPE_ALU_MUL_EN enables the multiplier inside pipe_alu_exec.
module pipelined_alu_rf
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned MDEPTH = 256
) (
  input logic              clk,
  input logic              rst,
  pipelined_alu_rf_if.slave bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned AW = $clog2(MDEPTH);

  logic [DW-1:0] rf_q  [NREG];
  logic [DW-1:0] mem_q [MDEPTH];

  logic          id_v_q, id_rf_we_q, id_mem_we_q;
  logic [RW-1:0] id_rd_q;
  logic [AW-1:0] id_addr_q;
  logic [2:0]    id_func_q;
  logic [DW-1:0] id_a_q, id_b_q;
  logic [DW-1:0] opa, opb;
  logic [DW-1:0] alu_res;
  logic          alu_div0;
  stage_t        ex_d, ex_q, wb_q;

  logic          res_valid_q, err_div0_q;
  logic [DW-1:0] res_data_q;
  logic [RW-1:0] res_rd_q;

  logic          id_fwd, ex_fwd;

  pipe_alu_exec #(.DW(DW)) u_exec (
    .func   (id_func_q),
    .a      (id_a_q),
    .b      (id_b_q),
    .result (alu_res),
    .div0   (alu_div0)
  );

  assign id_fwd = id_v_q && id_rf_we_q;
  assign ex_fwd = ex_q.v && ex_q.rf_we;

  // Operand bypass: youngest producer (ID, via live ALU output) wins over EX, then the RF.
  always_comb begin
    opa = rf_q[bus.rs1];
    opb = rf_q[bus.rs2];
    if (ex_fwd && ex_q.rd[RW-1:0] == bus.rs1) opa = ex_q.data[DW-1:0];
    if (ex_fwd && ex_q.rd[RW-1:0] == bus.rs2) opb = ex_q.data[DW-1:0];
    if (id_fwd && id_rd_q == bus.rs1) opa = alu_res;
    if (id_fwd && id_rd_q == bus.rs2) opb = alu_res;
  end

  // Pack the executed instruction into the stage record.
  always_comb begin
    ex_d        = '0;
    ex_d.v      = id_v_q;
    ex_d.rd     = RW_MAX'(id_rd_q);
    ex_d.rf_we  = id_rf_we_q;
    ex_d.mem_we = id_mem_we_q;
    ex_d.addr   = AW_MAX'(id_addr_q);
    ex_d.data   = DW_MAX'(alu_res);
    ex_d.div0   = alu_div0;
  end

  // ID datapath fields; only id_v_q needs to be cleared to squash them.
  always_ff @(posedge clk) begin
    id_rd_q     <= bus.rd;
    id_rf_we_q  <= bus.rf_we;
    id_mem_we_q <= bus.mem_we;
    id_addr_q   <= bus.addr;
    id_func_q   <= bus.func;
    id_a_q      <= opa;
    id_b_q      <= opb;
  end

  // Stage valids, EX/WB records and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_v_q      <= 1'b0;
      ex_q        <= '0;
      wb_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      err_div0_q  <= 1'b0;
    end else begin
      id_v_q      <= bus.in_valid;
      ex_q        <= ex_d;
      wb_q        <= ex_q;
      res_valid_q <= ex_q.v;
      err_div0_q  <= ex_q.v && ex_q.div0;
      // Bubbles leave the last result visible.
      if (ex_q.v) begin
        res_data_q <= ex_q.data[DW-1:0];
        res_rd_q   <= ex_q.rd[RW-1:0];
      end
    end
  end

  // Register file: reset to Reg[i] = i+1, written from EX at the WB edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= DW'(i + 1);
    end else if (ex_q.v && ex_q.rf_we) begin
      rf_q[ex_q.rd[RW-1:0]] <= ex_q.data[DW-1:0];
    end
  end

  // Data memory store one stage after writeback; reset blocks the write but does not clear.
  always_ff @(posedge clk) begin
    if (!rst && wb_q.v && wb_q.mem_we) begin
      mem_q[wb_q.addr[AW-1:0]] <= wb_q.data[DW-1:0];
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.err_div0  = err_div0_q;
  assign bus.mem_rdata = mem_q[bus.mem_raddr];

endmodule

// File: tb/tb_pipelined_alu_rf.sv
// Self-checking bench for pipelined_alu_rf (DW=16, NREG=16, MDEPTH=256).
// Reference: architectural program-order model of the RF and memory, plus a
// fixed 3-instruction result delay line.
module tb_pipelined_alu_rf;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, DIV = 3'd2, MUL = 3'd3;
  localparam logic [2:0] RSH = 3'd4, LSH = 3'd5, AND = 3'd6, XOR = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_alu_rf_if #(.DW(16), .NREG(16), .MDEPTH(256)) bus ();

  pipelined_alu_rf #(.DW(16), .NREG(16), .MDEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          v;
    logic [15:0] data;
    logic [3:0]  rd;
    bit          div0;
    bit          mem_we;
    logic [7:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_rf     [16];
  logic [15:0] m_mem    [256];
  bit          m_mem_ok [256];
  logic [15:0] last_data;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] model_alu(input logic [2:0] f, input logic [15:0] a,
                                            input logic [15:0] b, output bit d0);
    d0 = 1'b0;
    case (f)
      ADD: return a + b;
      SUB: return a - b;
      DIV: begin
        if (b == 16'd0) begin
          d0 = 1'b1;
          return 16'hFFFF;
        end
        return a / b;
      end
`ifdef PIPE_ALU_MUL_EN
      MUL: return a * b;
`else
      MUL: return 16'd0;
`endif
      RSH: return a >> (b % 16);
      LSH: return a << (b % 16);
      AND: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    check("res_valid", 32'(bus.res_valid), 32'(e.v));
    if (e.v) begin
      last_data = e.data;
      check("res_data", 32'(bus.res_data), 32'(e.data));
      check("res_rd", 32'(bus.res_rd), 32'(e.rd));
      check("err_div0", 32'(bus.err_div0), 32'(e.div0));
      if (e.mem_we) begin
        m_mem[e.addr]    = e.data;
        m_mem_ok[e.addr] = 1'b1;
      end
    end else begin
      check("res_data_hold", 32'(bus.res_data), 32'(last_data));
    end
  endtask

  task automatic push_bubble();
    exp_t e;
    e.v = 1'b0; e.data = '0; e.rd = '0; e.div0 = 1'b0; e.mem_we = 1'b0; e.addr = '0;
    exp_q.push_back(e);
  endtask

  // One instruction slot: drive, model in program order, clock, check the slot 2 edges older.
  task automatic step(input bit v, input int s1, input int s2, input int d, input logic [2:0] f,
                      input bit rfwe, input bit mwe, input int ad);
    exp_t e;
    bus.in_valid = v;
    bus.rs1 = 4'(s1); bus.rs2 = 4'(s2); bus.rd = 4'(d);
    bus.func = f; bus.rf_we = rfwe; bus.mem_we = mwe; bus.addr = 8'(ad);
    e.v = v; e.rd = 4'(d); e.mem_we = mwe; e.addr = 8'(ad); e.div0 = 1'b0; e.data = '0;
    if (v) begin
      e.data = model_alu(f, m_rf[s1], m_rf[s2], e.div0);
      if (rfwe) m_rf[d] = e.data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check_out(e);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, ADD, 1'b0, 1'b0, 0);
  endtask

  // Reset with a live instruction on the bus, which must be ignored.
  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.rs1 = 4'd1; bus.rs2 = 4'd2; bus.rd = 4'd1;
    bus.func = ADD; bus.rf_we = 1'b1; bus.mem_we = 1'b1; bus.addr = 8'hFF;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'(i + 1);
    last_data = '0;
    exp_q.delete();
    push_bubble();
    push_bubble();
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_rd", 32'(bus.res_rd), 32'd0);
    check("rst_err_div0", 32'(bus.err_div0), 32'd0);
  endtask

  task automatic check_mem(input int ad);
    bus.mem_raddr = 8'(ad);
    #1;
    check("mem_rdata", 32'(bus.mem_rdata), 32'(m_mem[ad]));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0;
    bus.rf_we = 1'b0; bus.mem_we = 1'b0; bus.addr = '0; bus.mem_raddr = '0;
    for (int i = 0; i < 256; i++) m_mem_ok[i] = 1'b0;
    do_reset(2);

    // r4 = r2 + r3 = 3 + 4 = 7, then read it back.
    step(1'b1, 2, 3, 4, ADD, 1'b1, 1'b0, 0);
    bubbles(3);
    step(1'b1, 4, 4, 0, AND, 1'b0, 1'b0, 0);
    // Back-to-back dependents: 5, 10, 8 with no stall.
    step(1'b1, 1, 2, 5, ADD, 1'b1, 1'b0, 0);
    step(1'b1, 5, 5, 6, ADD, 1'b1, 1'b0, 0);
    step(1'b1, 6, 1, 7, SUB, 1'b1, 1'b0, 0);
    // r0 = 0, div by zero, then 12/4.
    step(1'b1, 1, 1, 0, SUB, 1'b1, 1'b0, 0);
    step(1'b1, 3, 0, 13, DIV, 1'b0, 1'b0, 0);
    step(1'b1, 11, 3, 13, DIV, 1'b0, 1'b0, 0);
    // Shifts: 3 << (17 mod 16), 0x8000 >> 15, then and/xor patterns.
    step(1'b1, 1, 14, 8, ADD, 1'b1, 1'b0, 0);
    step(1'b1, 2, 8, 13, LSH, 1'b0, 1'b0, 0);
    step(1'b1, 11, 11, 9, DIV, 1'b1, 1'b0, 0);
    step(1'b1, 9, 14, 10, LSH, 1'b1, 1'b0, 0);
    step(1'b1, 10, 14, 13, RSH, 1'b0, 1'b0, 0);
    step(1'b1, 12, 13, 15, AND, 1'b0, 1'b0, 0);
    step(1'b1, 12, 13, 15, XOR, 1'b0, 1'b0, 0);
    step(1'b1, 2, 3, 15, MUL, 1'b0, 1'b0, 0);
    // Store 7 + 2 = 9 to 0xFF, visible one cycle after res_valid.
    step(1'b1, 4, 1, 12, ADD, 1'b1, 1'b1, 8'hFF);
    bubbles(3);
    check_mem(8'hFF);
    // Bubble carrying mem_we must not write.
    step(1'b0, 1, 1, 1, ADD, 1'b1, 1'b1, 8'hFF);
    bubbles(4);
    check_mem(8'hFF);

    // Reset with three instructions in flight: no writes reach RF or memory.
    step(1'b1, 1, 1, 1, ADD, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 2, 2, 2, ADD, 1'b1, 1'b1, 8'hFF);
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, i, i, i, AND, 1'b0, 1'b0, 0);
    bubbles(3);
    check_mem(8'hFF);

    // Randomised traffic against the program-order model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 8), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(32, 47)));
    end
    bubbles(4);
    for (int a = 32; a < 48; a++) if (m_mem_ok[a]) check_mem(a);
    for (int i = 0; i < 16; i++) step(1'b1, i, i, i, AND, 1'b0, 1'b0, 0);
    bubbles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
